// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS fetch-stage branch predictor:
// PC increment, saturating counter arithmetic and index-width calculation.
package mips_pkg;

   localparam int PC_INC    = 4;
   localparam int CTR_MAX_W = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Counters up to CTR_MAX_W bits wide travel through these helpers zero-extended.
   function automatic logic [CTR_MAX_W-1:0] ctr_max(input int bits);
      return CTR_MAX_W'((1 << bits) - 1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_wt(input int bits);
      return CTR_MAX_W'(1 << (bits - 1));
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_wnt(input int bits);
      return ctr_wt(bits) - CTR_MAX_W'(1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_inc(input logic [CTR_MAX_W-1:0] v,
                                                    input int bits);
      return (v >= ctr_max(bits)) ? ctr_max(bits) : v + CTR_MAX_W'(1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_dec(input logic [CTR_MAX_W-1:0] v);
      return (v == '0) ? '0 : v - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Width-generic up/down counter that saturates at both ends, with a
// synchronous load and asynchronous active-low reset.
module mips_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (inc && !dec && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else if (dec && !inc && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BHT + BTB: combinational next-PC prediction from the fetch PC,
// registered training from execute, and saturating lookup/mispredict stats.
module mips_branch_predictor
   import mips_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int ENTRIES  = 16,
   parameter int TAG_W    = 8,
   parameter int CTR_BITS = 2,
   parameter int STAT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   output logic [ADDR_W-1:0] pred_next_pc,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic [STAT_W-1:0] lookup_count,
   output logic [STAT_W-1:0] mispred_count
);

   localparam int                IDX_W = clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(ctr_wt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q [ENTRIES];
   logic [TAG_W-1:0]    tag_d [ENTRIES];
   logic [ADDR_W-1:0]   tgt_q [ENTRIES];
   logic [ADDR_W-1:0]   tgt_d [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_d [ENTRIES];

   logic [IDX_W-1:0] fetch_idx, upd_idx;
   logic [TAG_W-1:0] fetch_tag, upd_tag;
   logic             fetch_hit, upd_hit, mispredict;
   logic             unused_upd_pc;

   assign fetch_idx = fetch_pc[IDX_W+1:2];
   assign fetch_tag = fetch_pc[IDX_W+2 +: TAG_W];
   assign upd_idx   = upd_pc[IDX_W+1:2];
   assign upd_tag   = upd_pc[IDX_W+2 +: TAG_W];
   assign unused_upd_pc = ^upd_pc;

   assign fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign pred_taken   = fetch_hit && ctr_q[fetch_idx][CTR_BITS-1];
   assign pred_target  = fetch_hit ? tgt_q[fetch_idx] : '0;
   assign pred_next_pc = pred_taken ? pred_target : fetch_pc + ADDR_W'(PC_INC);

   // Flush drops any concurrent update; a taken miss evicts whatever is resident.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      if (flush) begin
         valid_d = '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               ctr_d[upd_idx] = CTR_BITS'(ctr_inc(CTR_MAX_W'(ctr_q[upd_idx]), CTR_BITS));
               tgt_d[upd_idx] = upd_target;
            end else begin
               ctr_d[upd_idx] = CTR_BITS'(ctr_dec(CTR_MAX_W'(ctr_q[upd_idx])));
            end
         end else if (upd_taken) begin
            valid_d[upd_idx] = 1'b1;
            tag_d[upd_idx]   = upd_tag;
            tgt_d[upd_idx]   = upd_target;
            ctr_d[upd_idx]   = WT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= WNT;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         ctr_q   <= ctr_d;
      end
   end

   assign mispredict = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

   mips_sat_counter #(.W(STAT_W)) u_lookup_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (!flush),
      .dec      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .count    (lookup_count)
   );

   mips_sat_counter #(.W(STAT_W)) u_mispred_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (mispredict),
      .dec      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .count    (mispred_count)
   );

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Self-checking bench for mips_branch_predictor: prediction expectations are
// queued when a fetch PC is driven and popped/compared once outputs settle.
module tb_mips_branch_predictor;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] next_pc;
   } exp_t;

   logic        clk, rst, flush;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target, pred_next_pc;
   logic        upd_valid, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic [15:0] lookup_count, mispred_count;

   logic        s4_pred_taken;
   logic [31:0] s4_pred_target, s4_pred_next_pc;
   logic [3:0]  s4_lookup_count, s4_mispred_count;

   exp_t        sb[$];
   int          checks, failures;
   logic [15:0] m_lookup, m_mispred;
   logic [3:0]  m_lookup4;

   mips_branch_predictor dut (
      .clk(clk), .rst(rst), .flush(flush), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_next_pc(pred_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .lookup_count(lookup_count), .mispred_count(mispred_count)
   );

   mips_branch_predictor #(.STAT_W(4)) dut_s4 (
      .clk(clk), .rst(rst), .flush(flush), .fetch_pc(fetch_pc),
      .pred_taken(s4_pred_taken), .pred_target(s4_pred_target), .pred_next_pc(s4_pred_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .lookup_count(s4_lookup_count), .mispred_count(s4_mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference statistics: counted from the driven inputs at each rising edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_lookup  = '0;
         m_lookup4 = '0;
         m_mispred = '0;
      end else begin
         if (!flush) begin
            if (m_lookup != 16'hFFFF) m_lookup = m_lookup + 16'd1;
            if (m_lookup4 != 4'hF) m_lookup4 = m_lookup4 + 4'd1;
         end
         if (upd_valid && ((upd_pred_taken != upd_taken) ||
                           (upd_taken && upd_pred_taken && (upd_pred_target != upd_target))))
            if (m_mispred != 16'hFFFF) m_mispred = m_mispred + 16'd1;
      end
   end

   task automatic push_lookup(input logic [31:0] pc, input logic tk,
                              input logic [31:0] tg, input logic [31:0] nx);
      exp_t e;
      e.taken   = tk;
      e.target  = tg;
      e.next_pc = nx;
      fetch_pc  = pc;
      sb.push_back(e);
   endtask

   task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                            input logic ptk, input logic [31:0] ptg);
      upd_pc          = pc;
      upd_taken       = tk;
      upd_target      = tg;
      upd_pred_taken  = ptk;
      upd_pred_target = ptg;
      upd_valid       = 1'b1;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
      push_lookup(32'h8, 1'b0, 32'h0, 32'hC);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL reset_lookup: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      checks++;
      if (lookup_count !== 16'd0 || mispred_count !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", lookup_count, mispred_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (lookup_count !== 16'd3) begin
         failures++;
         $display("[TB] FAIL lookup_per_cycle: got %0d expected 3", lookup_count);
      end
   endtask

   task automatic test_training();
      exp_t e;
      logic [2:0] exp_nt;
      exp_nt = 3'b001;
      do_update(32'h8, 1'b1, 32'h10, 1'b0, 32'h0);
      checks++;
      if (mispred_count !== 16'd1) begin
         failures++;
         $display("[TB] FAIL train_mispred: got %0d expected 1", mispred_count);
      end
      push_lookup(32'h8, 1'b1, 32'h10, 32'h10);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL train_alloc: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      do_update(32'h8, 1'b1, 32'h10, 1'b1, 32'h10);
      do_update(32'h8, 1'b1, 32'h10, 1'b1, 32'h10);
      for (int i = 0; i < 3; i++) begin
         do_update(32'h8, 1'b0, 32'h0, 1'b1, 32'h10);
         push_lookup(32'h8, exp_nt[i], 32'h10, exp_nt[i] ? 32'h10 : 32'hC);
         #1;
         e = sb.pop_front();
         checks++;
         if ({pred_taken, pred_target, pred_next_pc} !== e) begin
            failures++;
            $display("[TB] FAIL train_not_taken_%0d: got %h expected %h", i,
                     {pred_taken, pred_target, pred_next_pc}, e);
         end
      end
      do_update(32'h8, 1'b0, 32'h0, 1'b0, 32'h10);
      do_update(32'h8, 1'b1, 32'h10, 1'b0, 32'h0);
      push_lookup(32'h8, 1'b0, 32'h10, 32'hC);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL train_floor: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      checks++;
      if (mispred_count !== m_mispred) begin
         failures++;
         $display("[TB] FAIL train_mispred_total: got %0d expected %0d", mispred_count, m_mispred);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      upd_pc = 32'hC; upd_taken = 1'b1; upd_target = 32'h30;
      upd_pred_taken = 1'b0; upd_pred_target = 32'h0; upd_valid = 1'b1;
      @(posedge clk);
      #1;
      upd_taken = 1'b0;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      push_lookup(32'hC, 1'b0, 32'h30, 32'h10);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL back_to_back: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
   endtask

   task automatic test_aliasing();
      exp_t e;
      do_flush();
      do_update(32'h8, 1'b1, 32'h10, 1'b0, 32'h0);
      do_update(32'h48, 1'b1, 32'h80, 1'b0, 32'h0);
      push_lookup(32'h8, 1'b0, 32'h0, 32'hC);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL alias_evicted: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      push_lookup(32'h48, 1'b1, 32'h80, 32'h80);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL alias_resident: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
   endtask

   task automatic test_wrong_target();
      exp_t e;
      do_update(32'h48, 1'b1, 32'h24, 1'b1, 32'h20);
      checks++;
      if (mispred_count !== m_mispred) begin
         failures++;
         $display("[TB] FAIL wrong_target_count: got %0d expected %0d", mispred_count, m_mispred);
      end
      push_lookup(32'h48, 1'b1, 32'h24, 32'h24);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL wrong_target_tgt: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
   endtask

   task automatic test_flush();
      exp_t e;
      logic [31:0] pcs [3];
      pcs[0] = 32'h48; pcs[1] = 32'h8; pcs[2] = 32'h100;
      flush = 1'b1;
      upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
      upd_pred_taken = 1'b0; upd_pred_target = 32'h0; upd_valid = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      upd_valid = 1'b0;
      checks++;
      if (mispred_count !== m_mispred || lookup_count !== m_lookup) begin
         failures++;
         $display("[TB] FAIL flush_stats: got %0d/%0d expected %0d/%0d",
                  mispred_count, lookup_count, m_mispred, m_lookup);
      end
      for (int i = 0; i < 3; i++) begin
         push_lookup(pcs[i], 1'b0, 32'h0, pcs[i] + 32'd4);
         #1;
         e = sb.pop_front();
         checks++;
         if ({pred_taken, pred_target, pred_next_pc} !== e) begin
            failures++;
            $display("[TB] FAIL flush_miss_%0d: got %h expected %h", i,
                     {pred_taken, pred_target, pred_next_pc}, e);
         end
      end
      do_update(32'h48, 1'b1, 32'h50, 1'b0, 32'h0);
      push_lookup(32'h48, 1'b1, 32'h50, 32'h50);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL flush_retrain: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      do_update(32'h48, 1'b0, 32'h0, 1'b1, 32'h50);
      push_lookup(32'h48, 1'b0, 32'h50, 32'h4C);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL flush_retrain_wt: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
   endtask

   task automatic test_stats_and_reset();
      exp_t e;
      push_lookup(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL pc_wrap: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (s4_lookup_count !== 4'hF) begin
         failures++;
         $display("[TB] FAIL stat4_saturate: got %0d expected 15", s4_lookup_count);
      end
      checks++;
      if (lookup_count !== m_lookup || mispred_count !== m_mispred) begin
         failures++;
         $display("[TB] FAIL stats_running: got %0d/%0d expected %0d/%0d",
                  lookup_count, mispred_count, m_lookup, m_mispred);
      end
      do_update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      push_lookup(32'h100, 1'b1, 32'h200, 32'h200);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL pre_reset_pred: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0 || lookup_count !== 16'd0 ||
          mispred_count !== 16'd0 || s4_lookup_count !== 4'd0 || s4_mispred_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL async_reset: got pt=%b tgt=%h lc=%0d mc=%0d lc4=%0d mc4=%0d expected all 0",
                  pred_taken, pred_target, lookup_count, mispred_count, s4_lookup_count, s4_mispred_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      push_lookup(32'h100, 1'b0, 32'h0, 32'h104);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pred_taken, pred_target, pred_next_pc} !== e) begin
         failures++;
         $display("[TB] FAIL post_reset_miss: got %h expected %h", {pred_taken, pred_target, pred_next_pc}, e);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_training();
      test_back_to_back();
      test_aliasing();
      test_wrong_target();
      test_flush();
      test_stats_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
